// File: rtl/console_pkg.sv
// Shared constants and FSM encoding for the scrolling text console.
package console_pkg;

    localparam logic [7:0] SPACE       = 8'h20;
    localparam logic [7:0] PRINT_MAX   = 8'h7E;
    localparam logic [7:0] CR          = 8'h0D;
    localparam logic [7:0] LF          = 8'h0A;
    localparam logic [7:0] BS          = 8'h08;
    localparam logic [7:0] FF          = 8'h0C;
    localparam logic [7:0] CURSOR_CHAR = 8'h5F;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        CLEAR
    } state_t;

endpackage

// File: rtl/text_ram.sv
// Character buffer: one write port, one registered read port, read-before-write.
module text_ram #(
    parameter int DEPTH = 1200,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [7:0]    wd,
    input  logic [AW-1:0] ra,
    output logic [7:0]    rd
);

    logic [7:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; the console's INIT pass blanks it instead.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end

endmodule

// File: rtl/vga_text_console.sv
// Scrolling COLS x ROWS text console with a ring-buffered row pointer for scrolling.
// Optional blinking cursor overlay is built when CONSOLE_CURSOR_EN is defined.
module vga_text_console
    import console_pkg::*;
#(
    parameter int COLS         = 40,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_wr,
    input  logic [7:0]              i_data,
    output logic                    o_ready,
    input  logic [$clog2(COLS)-1:0] i_rd_col,
    input  logic [$clog2(ROWS)-1:0] i_rd_row,
    output logic [7:0]              o_rd_data,
    output logic                    o_rd_valid,
    input  logic                    i_frame,
    output logic [$clog2(COLS)-1:0] o_cur_col,
    output logic [$clog2(ROWS)-1:0] o_cur_row
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [CW-1:0] col, col_n;
    logic [RW-1:0] row, row_n, top, top_n, clr_row, clr_row_n;
    logic          newline;
    logic          we;
    logic [AW-1:0] wa, rd_addr;
    logic [7:0]    wd, ram_q;
    logic          rd_in_range, rd_valid_q, cursor_hit_q;

    // Logical row to physical row: top is the physical row shown as line 0.
    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] r, input logic [RW-1:0] t);
        logic [RW:0] s;
        s = {1'b0, r} + {1'b0, t};
        if (s >= (RW+1)'(ROWS)) s = s - (RW+1)'(ROWS);
        return s[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] p, input logic [CW-1:0] c);
        return AW'(p) * AW'(COLS) + AW'(c);
    endfunction

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= INIT;
            cnt     <= '0;
            col     <= '0;
            row     <= '0;
            top     <= '0;
            clr_row <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            col     <= col_n;
            row     <= row_n;
            top     <= top_n;
            clr_row <= clr_row_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        col_n     = col;
        row_n     = row;
        top_n     = top;
        clr_row_n = clr_row;
        newline   = 1'b0;
        we        = 1'b0;
        wa        = '0;
        wd        = SPACE;
        unique case (state)
            INIT: begin
                we    = 1'b1;
                wa    = cnt;
                col_n = '0;
                row_n = '0;
                top_n = '0;
                if (cnt == AW'(DEPTH - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + AW'(1);
                end
            end
            IDLE: begin
                if (i_wr) begin
                    case (i_data)
                        CR: col_n = '0;
                        LF: newline = 1'b1;
                        BS: if (col != '0) col_n = col - CW'(1);
                        FF: begin
                            state_n = INIT;
                            cnt_n   = '0;
                            col_n   = '0;
                            row_n   = '0;
                            top_n   = '0;
                        end
                        default: begin
                            if (i_data >= SPACE && i_data <= PRINT_MAX) begin
                                we = 1'b1;
                                wa = cell_addr(phys_row(row, top), col);
                                wd = i_data;
                                if (col == COL_LAST) newline = 1'b1;
                                else                 col_n   = col + CW'(1);
                            end
                        end
                    endcase
                end
                if (newline) begin
                    col_n = '0;
                    if (row != ROW_LAST) begin
                        row_n = row + RW'(1);
                    end else begin
                        // The old top physical row becomes the new bottom line.
                        top_n     = (top == ROW_LAST) ? '0 : top + RW'(1);
                        clr_row_n = top;
                        state_n   = CLEAR;
                        cnt_n     = '0;
                    end
                end
            end
            CLEAR: begin
                we = 1'b1;
                wa = AW'(clr_row) * AW'(COLS) + cnt;
                if (cnt == AW'(COLS - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + AW'(1);
                end
            end
            default: state_n = INIT;
        endcase
    end

    assign rd_in_range = ({1'b0, i_rd_col} < (CW+1)'(COLS)) && ({1'b0, i_rd_row} < (RW+1)'(ROWS));
    assign rd_addr     = rd_in_range ? cell_addr(phys_row(i_rd_row, top), i_rd_col) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_valid_q <= 1'b0;
        else          rd_valid_q <= rd_in_range && (state != INIT);
    end

    text_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk (clk),
        .we  (we),
        .wa  (wa),
        .wd  (wd),
        .ra  (rd_addr),
        .rd  (ram_q)
    );

`ifdef CONSOLE_CURSOR_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] frame_cnt;
    logic          blink;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt    <= '0;
            blink        <= 1'b0;
            cursor_hit_q <= 1'b0;
        end else begin
            if (i_frame) begin
                if (frame_cnt == BW'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    frame_cnt <= frame_cnt + BW'(1);
                end
            end
            cursor_hit_q <= blink && (i_rd_col == col) && (i_rd_row == row);
        end
    end
`else
    logic unused_frame;
    assign unused_frame = i_frame | (BLINK_FRAMES < 1);
    assign cursor_hit_q = 1'b0;
`endif

    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = !rd_valid_q ? SPACE : (cursor_hit_q ? CURSOR_CHAR : ram_q);
    assign o_ready    = (state == IDLE);
    assign o_cur_col  = col;
    assign o_cur_row  = row;

endmodule

// File: tb/tb_vga_text_console.sv
// Self-checking bench for vga_text_console: logical-screen model plus read scoreboard.
module tb_vga_text_console;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int DEPTH = COLS * ROWS;
    localparam int BLINK = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_wr = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic [5:0] i_rd_col = '0;
    logic [4:0] i_rd_row = '0;
    logic       i_frame = 1'b0;
    logic       o_ready, o_rd_valid;
    logic [7:0] o_rd_data;
    logic [5:0] o_cur_col;
    logic [4:0] o_cur_row;

    vga_text_console #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BLINK)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wr       (i_wr),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .i_rd_col   (i_rd_col),
        .i_rd_row   (i_rd_row),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .i_frame    (i_frame),
        .o_cur_col  (o_cur_col),
        .o_cur_row  (o_cur_row)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] data;
        logic       valid;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] scr [ROWS][COLS];
    int         mcol, mrow, mframes;
    bit         mphase;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_blank();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h20;
        mcol = 0;
        mrow = 0;
    endtask

    task automatic model_newline(output int kind);
        kind = 0;
        mcol = 0;
        if (mrow < ROWS - 1) begin
            mrow++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
            kind = 1;
        end
    endtask

    // kind: 0 = no busy period, 1 = row clear, 2 = full init
    task automatic model_byte(input logic [7:0] b, output int kind);
        kind = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mrow][mcol] = b;
            if (mcol == COLS - 1) model_newline(kind);
            else                  mcol++;
        end else begin
            case (b)
                8'h0D: mcol = 0;
                8'h0A: model_newline(kind);
                8'h08: if (mcol > 0) mcol--;
                8'h0C: begin model_blank(); kind = 2; end
                default: ;
            endcase
        end
    endtask

    task automatic measure_low(input string tag, input int exp);
        int n = 0;
        while (!o_ready && n < DEPTH + 100) begin
            n++;
            step();
        end
        check(tag, n, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < DEPTH + 100) begin
            n++;
            step();
        end
        check("ready_before_send", o_ready, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit measure);
        int kind;
        wait_ready();
        i_wr   = 1'b1;
        i_data = b;
        step();
        i_wr = 1'b0;
        model_byte(b, kind);
        if (measure && kind == 1) measure_low("clear_len", COLS);
        if (measure && kind == 2) measure_low("init_len", DEPTH);
    endtask

    task automatic read_cell(input int c, input int r);
        exp_t e, got;
        e.tag = $sformatf("rd(%0d,%0d)", c, r);
        if (c < COLS && r < ROWS) begin
            e.valid = 1'b1;
            e.data  = (mphase && c == mcol && r == mrow) ? 8'h5F : scr[r][c];
        end else begin
            e.valid = 1'b0;
            e.data  = 8'h20;
        end
        sb.push_back(e);
        i_rd_col = 6'(c);
        i_rd_row = 5'(r);
        step();
        got = sb.pop_front();
        check({got.tag, "_data"}, o_rd_data, got.data);
        check({got.tag, "_valid"}, o_rd_valid, got.valid);
    endtask

    task automatic check_screen();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                read_cell(c, r);
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_col"}, o_cur_col, mcol);
        check({tag, "_row"}, o_cur_row, mrow);
    endtask

    task automatic pulse_frames(input int n, input bit modeled);
        for (int i = 0; i < n; i++) begin
            i_frame = 1'b1;
            step();
            if (modeled) begin
                mframes++;
                if (mframes == BLINK) begin
                    mframes = 0;
                    mphase  = ~mphase;
                end
            end
        end
        i_frame = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_wr    = 1'b0;
        step();
        step();
        check("rst_ready", o_ready, 1'b0);
        check("rst_cur_col", o_cur_col, 0);
        check("rst_cur_row", o_cur_row, 0);
        check("rst_rd_valid", o_rd_valid, 1'b0);
        check("rst_rd_data", o_rd_data, 8'h20);
        reset_n = 1'b1;
        model_blank();
        mframes = 0;
        mphase  = 1'b0;
        measure_low("reset_init_len", DEPTH);
    endtask

    initial begin
        int n;
        model_blank();
        mframes = 0;
        mphase  = 1'b0;
        step();
        do_reset();

        read_cell(0, 0);
        read_cell(COLS - 1, ROWS - 1);
        read_cell(COLS, 0);
        read_cell(0, ROWS);

        send_byte("A", 1);
        send_byte("B", 1);
        read_cell(0, 0);
        read_cell(1, 0);
        check_cursor("cur_ab");
        send_byte(8'h08, 1);
        send_byte("C", 1);
        read_cell(1, 0);
        read_cell(2, 0);
        check_cursor("cur_bs");

        send_byte(8'h0C, 1);
        check_cursor("cur_ff");
        read_cell(0, 0);
        for (int i = 0; i < COLS; i++) send_byte("x", 1);
        for (int c = 0; c < COLS; c++) read_cell(c, 0);
        read_cell(0, 1);
        check_cursor("cur_wrap");
        send_byte(8'h0D, 1);
        send_byte(8'h0A, 1);
        check_cursor("cur_crlf");

        send_byte(8'h0C, 1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < ((r == ROWS - 1) ? COLS - 1 : COLS); c++)
                send_byte(8'h41 + 8'(r), 1);
        send_byte(8'h0A, 1);
        check_cursor("cur_scroll");
        check_screen();

        send_byte(8'h0C, 1);
        check_cursor("cur_ff2");
        check_screen();

        for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A, 1);
        send_byte(8'h0A, 0);
        step();
        step();
        check("in_clear_ready", o_ready, 1'b0);
        do_reset();
        check_cursor("cur_after_rst");
        read_cell(0, 0);
        read_cell(COLS - 1, ROWS - 1);

        send_byte(8'h0C, 0);
        i_wr   = 1'b1;
        i_data = "Z";
        n = 0;
        while (!o_ready && n < DEPTH + 100) begin
            n++;
            step();
        end
        i_wr = 1'b0;
        check("init_len_wr_held", n, DEPTH);
        check_screen();

        send_byte("a", 1);
        send_byte("b", 1);
        send_byte("c", 1);
        check_cursor("cur_blink");
`ifdef CONSOLE_CURSOR_EN
        pulse_frames(BLINK, 1);
        read_cell(3, 0);
        read_cell(4, 0);
        pulse_frames(BLINK, 1);
        read_cell(3, 0);
`else
        pulse_frames(BLINK, 0);
        read_cell(3, 0);
        read_cell(2, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_text_console.md
# vga_text_console

Scrolling character-grid text console for the VGA text pipeline. Accepts a byte stream (typically from the UART receiver) through a valid/ready handshake, interprets printable ASCII and a small set of control codes, and maintains a COLS×ROWS character buffer with cursor, line wrap and hardware scroll. The display side reads characters by (column, row) with one-cycle latency and feeds them to the hex2asc/font stages.

## Interface
- COLS, 40, characters per row (≥2).
- ROWS, 30, rows on screen (≥2; need not be a power of 2).
- BLINK_FRAMES, 16, frame pulses per cursor blink half-period (used only when the cursor is compiled in).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_wr  in  1  input byte valid.
- i_data  in  8  input byte.
- o_ready  out  1  console can accept a byte this cycle.
- i_rd_col  in  $clog2(COLS)  display read column.
- i_rd_row  in  $clog2(ROWS)  display read row (logical: 0 = top line).
- o_rd_data  out  8  character at the requested cell.
- o_rd_valid  out  1  o_rd_data is meaningful.
- i_frame  in  1  one-cycle pulse per video frame.
- o_cur_col  out  $clog2(COLS)  cursor column.
- o_cur_row  out  $clog2(ROWS)  cursor row (logical).

## Operation
- Byte accepted on a rising clk with i_wr & o_ready. i_wr while o_ready=0 is ignored; the byte is lost.
- FSM states:
  - INIT: writes 0x20 to every cell, one per cycle, COLS*ROWS cycles; cursor=(0,0); top=0; then IDLE.
  - IDLE: o_ready=1.
  - CLEAR: blanks one physical row, COLS cycles; then IDLE.
- Byte decode in IDLE:
  - 0x20–0x7E: written at the cursor; col+1. If col was COLS-1, perform a newline.
  - 0x0D (CR): col=0.
  - 0x0A (LF): newline.
  - 0x08 (BS): col-1, saturating at 0; no erase.
  - 0x0C (FF): go to INIT.
  - Any other byte: consumed, no effect.
- Newline: col=0.
  - If row<ROWS-1: row+1.
  - Otherwise scroll: top=(top+1) mod ROWS, row stays ROWS-1, enter CLEAR on the new bottom physical row.
- Physical row = (logical row + top) mod ROWS, computed by compare-subtract (no divider). RAM address = phys_row*COLS + col.
- Read port:
  - In-range coordinates: o_rd_data = cell content, o_rd_valid=1.
  - Out of range (col≥COLS or row≥ROWS): o_rd_data=0x20, o_rd_valid=0.
  - During INIT: o_rd_valid=0 and o_rd_data=0x20.
  - During CLEAR: reads are valid; a read of the row being cleared returns mixed old/blank content.
- Reset values: o_ready=0 (INIT starts), o_cur_col=0, o_cur_row=0, o_rd_data=0x20, o_rd_valid=0, top=0, blink phase=0.
- reset_n asserted mid-INIT or mid-CLEAR aborts the operation and restarts INIT after release.

## Timing
- Byte accepted at edge N:
  - Cursor outputs and RAM are updated at N+1.
  - A read issued in cycle N+1 returns the new content after edge N+2.
- Read latency is 1 cycle: coordinates sampled at edge K, o_rd_data/o_rd_valid valid after K.
- A read and a write to the same cell in the same cycle return the old data (read-before-write).
- o_ready falls in the cycle after a byte that triggers CLEAR or INIT is accepted.
  - CLEAR: o_ready stays low exactly COLS cycles.
  - INIT: o_ready stays low exactly COLS*ROWS cycles.
- i_frame is sampled synchronously; back-to-back pulses each count.

## Configuration
- CONSOLE_CURSOR_EN defined:
  - A counter of i_frame pulses toggles the blink phase every BLINK_FRAMES pulses.
  - While phase=1, a valid read at (o_cur_col, o_cur_row) returns 0x5F instead of the RAM content.
- Undefined: no blink logic is built, i_frame is ignored, and reads always return RAM content.

## Structure
- Shared package console_pkg:
  - ASCII constants: SPACE 0x20, CR, LF, BS, FF, CURSOR_CHAR 0x5F.
  - FSM state encoding INIT/IDLE/CLEAR.
- Sub-module text_ram: simple synchronous RAM with one write port and one read port, depth COLS*ROWS, 8-bit data, read-before-write.

## Test plan
- Reset release with defaults: o_ready low for exactly 1200 cycles, then high. Reads of (0,0) and (39,29) return 0x20 with o_rd_valid=1. A read of col 40 returns o_rd_valid=0.
- Send "AB": (0,0)=0x41, (1,0)=0x42, cursor=(2,0). Send 0x08 then 'C': (1,0)=0x43.
- Send 40 'x': row 0 is all 0x78, cursor=(0,1). Send CR LF: cursor=(0,2).
- Fill rows 0–29 with row-index letters ('A'+row), then send LF:
  - o_ready low exactly 40 cycles.
  - Logical row 0 reads 'B', row 28 reads the former last row, row 29 reads all 0x20.
  - Cursor=(0,29).
- Send FF mid-screen: o_ready low 1200 cycles, every cell 0x20, cursor=(0,0). Assert reset_n mid-CLEAR: INIT restarts and o_ready stays low 1200 cycles after release.
- CONSOLE_CURSOR_EN with cursor=(3,0):
  - After 16 i_frame pulses, a read at (3,0) returns 0x5F and (4,0) returns 0x20.
  - After 16 more pulses, (3,0) returns 0x20.
  - i_wr held high while o_ready=0: no cell changes.
